// File: rtl/mips_ctrl_pkg.sv
// rtl/mips_ctrl_pkg.sv - shared constants and MDU state encoding for the pipeline controller
package mips_ctrl_pkg;

  localparam int          TW          = 4;
  localparam logic [3:0]  TUSE_NONE   = 4'hF;
  localparam int          MULT_CYCLES = 5;
  localparam int          DIV_CYCLES  = 10;

  typedef enum logic [1:0] {
    MDU_IDLE = 2'd0,
    MDU_MUL  = 2'd1,
    MDU_DIV  = 2'd2
  } mdu_state_t;

  // Counter must hold the longer latency minus one, and is never narrower than 4 bits.
  function automatic int mdu_cnt_width(input int mult_cycles, input int div_cycles);
    int longest;
    int w;
    longest = (mult_cycles > div_cycles) ? mult_cycles : div_cycles;
    w = $clog2(longest);
    return (w < 4) ? 4 : w;
  endfunction

endpackage

// File: rtl/mdu_seq.sv
// rtl/mdu_seq.sv - MDU busy sequencer: IDLE/MUL/DIV FSM with a latency down-counter
module mdu_seq #(
  parameter int MULT_CYCLES = mips_ctrl_pkg::MULT_CYCLES,
  parameter int DIV_CYCLES  = mips_ctrl_pkg::DIV_CYCLES
) (
  input  logic clk,
  input  logic reset,
  input  logic md_go,
  input  logic E_md_div,
  output logic md_busy
);
  import mips_ctrl_pkg::*;

  localparam int CW = mdu_cnt_width(MULT_CYCLES, DIV_CYCLES);

  mdu_state_t    state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= MDU_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Loading N-1 and leaving on cnt==0 gives exactly N busy cycles after the start edge.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      MDU_IDLE: begin
        if (md_go) begin
          state_nxt = E_md_div ? MDU_DIV : MDU_MUL;
          cnt_nxt   = E_md_div ? CW'(DIV_CYCLES - 1) : CW'(MULT_CYCLES - 1);
        end
      end
      MDU_MUL, MDU_DIV: begin
        if (cnt == '0) begin
          state_nxt = MDU_IDLE;
        end else begin
          cnt_nxt = cnt - CW'(1);
        end
      end
      default: begin
        state_nxt = MDU_IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  assign md_busy = (state != MDU_IDLE);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - pipeline stall controller (Tuse/Tnew, MDU, ERET); PIPE_CTRL_PERF_EN adds stall_cnt
module pipe_hazard_ctrl #(
  parameter int MULT_CYCLES = mips_ctrl_pkg::MULT_CYCLES,
  parameter int DIV_CYCLES  = mips_ctrl_pkg::DIV_CYCLES,
  parameter int TW          = mips_ctrl_pkg::TW
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          Req,
  input  logic [4:0]    D_rs,
  input  logic [4:0]    D_rt,
  input  logic [TW-1:0] D_rs_Tuse,
  input  logic [TW-1:0] D_rt_Tuse,
  input  logic          D_is_md,
  input  logic          D_is_eret,
  input  logic [4:0]    E_A3,
  input  logic [4:0]    M_A3,
  input  logic          E_write,
  input  logic          M_write,
  input  logic [TW-1:0] E_Tnew,
  input  logic [TW-1:0] M_Tnew,
  input  logic          E_md_start,
  input  logic          E_md_div,
  input  logic          E_mtc0_epc,
  input  logic          M_mtc0_epc,
  output logic          PC_EN,
  output logic          F_D_EN,
  output logic          D_E_clr,
  output logic          md_go,
  output logic          md_busy,
  output logic [31:0]   stall_cnt
);
  import mips_ctrl_pkg::*;

  logic rs_stall, rt_stall, md_stall, eret_stall, stall;

  always_comb begin
    rs_stall = (D_rs != 5'd0) &
               ((E_write & (E_A3 == D_rs) & (D_rs_Tuse < E_Tnew)) |
                (M_write & (M_A3 == D_rs) & (D_rs_Tuse < M_Tnew)));
    rt_stall = (D_rt != 5'd0) &
               ((E_write & (E_A3 == D_rt) & (D_rt_Tuse < E_Tnew)) |
                (M_write & (M_A3 == D_rt) & (D_rt_Tuse < M_Tnew)));
  end

  // Raw E_md_start counts here: the MDU result is unavailable even if the start is later cancelled.
  assign md_stall   = D_is_md & (md_busy | E_md_start);
  assign eret_stall = D_is_eret & (E_mtc0_epc | M_mtc0_epc);
  assign stall      = rs_stall | rt_stall | md_stall | eret_stall;

  assign md_go = reset & E_md_start & ~Req & ~md_busy;

  mdu_seq #(
    .MULT_CYCLES (MULT_CYCLES),
    .DIV_CYCLES  (DIV_CYCLES)
  ) u_mdu_seq (
    .clk      (clk),
    .reset    (reset),
    .md_go    (md_go),
    .E_md_div (E_md_div),
    .md_busy  (md_busy)
  );

  // Reset freezes fetch; Req overrides stalls because the pipeline registers flush on it.
  always_comb begin
    PC_EN   = 1'b1;
    F_D_EN  = 1'b1;
    D_E_clr = 1'b0;
    if (!reset) begin
      PC_EN   = 1'b0;
      F_D_EN  = 1'b0;
      D_E_clr = 1'b1;
    end else if (Req) begin
      PC_EN   = 1'b1;
      F_D_EN  = 1'b1;
      D_E_clr = 1'b0;
    end else if (stall) begin
      PC_EN   = 1'b0;
      F_D_EN  = 1'b0;
      D_E_clr = 1'b1;
    end
  end

`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] stall_cnt_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt_q <= 32'd0;
    end else if (stall & ~Req) begin
      stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign stall_cnt = stall_cnt_q;
`else
  assign stall_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb/tb_pipe_hazard_ctrl.sv - directed and randomized checks of pipe_hazard_ctrl against a behavioural model
module tb_pipe_hazard_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        Req;
  logic [4:0]  D_rs, D_rt, E_A3, M_A3;
  logic [3:0]  D_rs_Tuse, D_rt_Tuse, E_Tnew, M_Tnew;
  logic        D_is_md, D_is_eret, E_write, M_write;
  logic        E_md_start, E_md_div, E_mtc0_epc, M_mtc0_epc;
  logic        PC_EN, F_D_EN, D_E_clr, md_go, md_busy;
  logic [31:0] stall_cnt;

  int          passed = 0;
  int          total  = 0;
  int          rem    = 0;
  logic [31:0] exp_cnt = 32'd0;
  bit          cmp_en = 1'b0;

  pipe_hazard_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .Req        (Req),
    .D_rs       (D_rs),
    .D_rt       (D_rt),
    .D_rs_Tuse  (D_rs_Tuse),
    .D_rt_Tuse  (D_rt_Tuse),
    .D_is_md    (D_is_md),
    .D_is_eret  (D_is_eret),
    .E_A3       (E_A3),
    .M_A3       (M_A3),
    .E_write    (E_write),
    .M_write    (M_write),
    .E_Tnew     (E_Tnew),
    .M_Tnew     (M_Tnew),
    .E_md_start (E_md_start),
    .E_md_div   (E_md_div),
    .E_mtc0_epc (E_mtc0_epc),
    .M_mtc0_epc (M_mtc0_epc),
    .PC_EN      (PC_EN),
    .F_D_EN     (F_D_EN),
    .D_E_clr    (D_E_clr),
    .md_go      (md_go),
    .md_busy    (md_busy),
    .stall_cnt  (stall_cnt)
  );

  always #5 clk = ~clk;

  // A source register hazards when some older writer will not have its value ready by Tuse.
  function automatic bit hazard(input logic [4:0] r, input logic [3:0] tuse);
    if (r == 5'd0) return 1'b0;
    if (E_write && E_A3 == r && int'(tuse) < int'(E_Tnew)) return 1'b1;
    if (M_write && M_A3 == r && int'(tuse) < int'(M_Tnew)) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit model_stall();
    return hazard(D_rs, D_rs_Tuse) || hazard(D_rt, D_rt_Tuse) ||
           (D_is_md && (rem > 0 || E_md_start)) ||
           (D_is_eret && (E_mtc0_epc || M_mtc0_epc));
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  // Model state: remaining MDU busy cycles and the stall count.
  always @(posedge clk) begin
    if (!reset) begin
      rem     = 0;
      exp_cnt = 32'd0;
    end else begin
`ifdef PIPE_CTRL_PERF_EN
      if (model_stall() && !Req) exp_cnt = exp_cnt + 32'd1;
`endif
      if (rem > 0) rem = rem - 1;
      else if (E_md_start && !Req) rem = E_md_div ? 10 : 5;
    end
  end

  always @(negedge clk) begin
    bit st, run;
    if (cmp_en) begin
      st  = model_stall();
      run = reset && !Req && !st;
      chk("pc_en",     PC_EN,   (!reset) ? 1'b0 : (Req || run));
      chk("f_d_en",    F_D_EN,  (!reset) ? 1'b0 : (Req || run));
      chk("d_e_clr",   D_E_clr, (!reset) ? 1'b1 : (!Req && st));
      chk("md_go",     md_go,   reset && E_md_start && !Req && rem == 0);
      chk("md_busy",   md_busy, reset && rem > 0);
      chk("stall_cnt", stall_cnt, reset ? exp_cnt : 32'd0);
    end
  end

  task automatic idle();
    Req = 0; D_rs = 0; D_rt = 0; D_rs_Tuse = 4'hF; D_rt_Tuse = 4'hF;
    D_is_md = 0; D_is_eret = 0; E_A3 = 0; M_A3 = 0; E_write = 0; M_write = 0;
    E_Tnew = 0; M_Tnew = 0; E_md_start = 0; E_md_div = 0; E_mtc0_epc = 0; M_mtc0_epc = 0;
  endtask

  task automatic nxt();
    @(posedge clk); #1;
  endtask

  task automatic smp();
    @(negedge clk); #1;
  endtask

  task automatic randomize_inputs();
    logic [3:0] tuse_tab [5];
    tuse_tab = '{4'd0, 4'd1, 4'd2, 4'd3, 4'hF};
    Req        = ($urandom_range(0, 7) == 0);
    D_rs       = 5'($urandom_range(0, 3));
    D_rt       = 5'($urandom_range(0, 3));
    D_rs_Tuse  = tuse_tab[$urandom_range(0, 4)];
    D_rt_Tuse  = tuse_tab[$urandom_range(0, 4)];
    E_A3       = 5'($urandom_range(0, 3));
    M_A3       = 5'($urandom_range(0, 3));
    E_write    = $urandom_range(0, 1) == 1;
    M_write    = $urandom_range(0, 1) == 1;
    E_Tnew     = 4'($urandom_range(0, 3));
    M_Tnew     = 4'($urandom_range(0, 2));
    D_is_md    = ($urandom_range(0, 2) == 0);
    D_is_eret  = ($urandom_range(0, 3) == 0);
    E_mtc0_epc = ($urandom_range(0, 4) == 0);
    M_mtc0_epc = ($urandom_range(0, 4) == 0);
    E_md_start = (rem == 0) ? ($urandom_range(0, 5) == 0) : ($urandom_range(0, 39) == 0);
    E_md_div   = $urandom_range(0, 1) == 1;
  endtask

  initial begin
    idle();
    E_md_start = 1;
    cmp_en = 1;
    #2;
    chk("rst_pc_en",   PC_EN,   1'b0);
    chk("rst_d_e_clr", D_E_clr, 1'b1);
    chk("rst_md_go",   md_go,   1'b0);
    chk("rst_md_busy", md_busy, 1'b0);
    nxt(); idle(); reset = 1;

    // lw in E feeding add in D, then the same lw one stage later
    nxt(); idle(); E_write = 1; E_A3 = 5'd8; E_Tnew = 4'd2; D_rs = 5'd8; D_rs_Tuse = 4'd1;
    smp(); chk("t1_pc_en", PC_EN, 1'b0); chk("t1_d_e_clr", D_E_clr, 1'b1); chk("t1_f_d_en", F_D_EN, 1'b0);
    nxt(); E_write = 0; M_write = 1; M_A3 = 5'd8; M_Tnew = 4'd1;
    smp(); chk("t1b_pc_en", PC_EN, 1'b1); chk("t1b_d_e_clr", D_E_clr, 1'b0);

    nxt(); idle(); D_rs = 0; E_A3 = 0; E_write = 1; E_Tnew = 4'd2; D_rs_Tuse = 4'd0;
    smp(); chk("t2_zero_reg", PC_EN, 1'b1);

    nxt(); idle(); D_is_md = 1; E_md_start = 1; E_md_div = 0;
    smp(); chk("t3_go", md_go, 1'b1); chk("t3_pc_en_t0", PC_EN, 1'b0);
    for (int i = 1; i <= 5; i++) begin
      nxt(); E_md_start = 0;
      smp(); chk("t3_busy", md_busy, 1'b1); chk("t3_pc_en", PC_EN, 1'b0);
    end
    nxt(); smp(); chk("t3_busy_end", md_busy, 1'b0); chk("t3_pc_en_end", PC_EN, 1'b1);

    nxt(); idle(); E_md_start = 1; E_md_div = 1;
    smp(); chk("t4_go", md_go, 1'b1);
    for (int i = 1; i <= 10; i++) begin
      nxt(); E_md_start = 0; Req = (i == 3);
      smp(); chk("t4_busy", md_busy, 1'b1);
    end
    nxt(); Req = 0; smp(); chk("t4_busy_end", md_busy, 1'b0);

    nxt(); idle(); Req = 1; E_md_start = 1; D_is_md = 1;
    smp(); chk("t5_go", md_go, 1'b0); chk("t5_pc_en", PC_EN, 1'b1);
    chk("t5_f_d_en", F_D_EN, 1'b1); chk("t5_d_e_clr", D_E_clr, 1'b0);
    nxt(); idle(); smp(); chk("t5_busy", md_busy, 1'b0);

    nxt(); idle(); E_md_start = 1; E_md_div = 1;
    nxt(); E_md_start = 0; D_is_md = 1;
    nxt(); nxt(); nxt();
    reset = 0; #1;
    chk("t6_busy", md_busy, 1'b0); chk("t6_pc_en", PC_EN, 1'b0); chk("t6_stall_cnt", stall_cnt, 32'd0);
    nxt(); idle(); reset = 1;
    smp(); chk("t6_idle", md_busy, 1'b0); chk("t6_pc_en_after", PC_EN, 1'b1);

    for (int i = 0; i < 3000; i++) begin
      nxt();
      reset = 1;
      randomize_inputs();
      if ($urandom_range(0, 299) == 0) reset = 0;
    end
    nxt(); idle(); reset = 1;
    smp();
    cmp_en = 0;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
